// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder into a held-key bitmap; TYPEMATIC_FILTER_EN suppresses repeat events.
// Latency: byte strobe to key_down/last_change/been_ready is 1 clk, and any_key follows 1 clk later.
// Backpressure: none; the decoder accepts a byte on every cycle.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_err,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         been_ready,
    output logic         any_key
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(PAUSE_SKIP + 1);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   skip_cnt;

    logic            ev_vld;
    logic            ev_set;
    logic [8:0]      ev_code;
    logic            ev_fire;

    // Decode which key event (if any) the current byte produces in the current state.
    always_comb begin
        ev_vld  = 1'b0;
        ev_set  = 1'b0;
        ev_code = 9'd0;
        if (rx_valid && !rx_err) begin
            unique case (state)
                IDLE: begin
                    unique case (rx_data)
                        8'hE0, 8'hF0, 8'hE1,
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            ev_vld  = 1'b1;
                            ev_set  = 1'b1;
                            ev_code = {1'b0, rx_data};
                        end
                    endcase
                end
                EXT: begin
                    if (rx_data != 8'hF0 && rx_data != 8'hE0) begin
                        ev_vld  = 1'b1;
                        ev_set  = 1'b1;
                        ev_code = {1'b1, rx_data};
                    end
                end
                BRK: begin
                    ev_vld  = 1'b1;
                    ev_code = {1'b0, rx_data};
                end
                EXT_BRK: begin
                    ev_vld  = 1'b1;
                    ev_code = {1'b1, rx_data};
                end
                default: ;
            endcase
        end
`ifdef TYPEMATIC_FILTER_EN
        ev_fire = ev_vld && (key_down[ev_code] != ev_set);
`else
        ev_fire = ev_vld;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            skip_cnt    <= '0;
            key_down    <= '0;
            last_change <= '0;
            been_ready  <= 1'b0;
            any_key     <= 1'b0;
        end else begin
            been_ready <= ev_fire;
            any_key    <= |key_down;
            if (ev_fire) begin
                key_down[ev_code] <= ev_set;
                last_change       <= ev_code;
            end

            if (rx_err) begin
                state    <= IDLE;
                tmo_cnt  <= '0;
                skip_cnt <= '0;
            end else if (rx_valid) begin
                tmo_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (rx_data == 8'hE0) begin
                            state <= EXT;
                        end else if (rx_data == 8'hF0) begin
                            state <= BRK;
                        end else if (rx_data == 8'hE1) begin
                            state    <= SKIP;
                            skip_cnt <= SW'(PAUSE_SKIP);
                        end
                    end
                    EXT: begin
                        if (rx_data == 8'hF0) begin
                            state <= EXT_BRK;
                        end else if (rx_data != 8'hE0) begin
                            state <= IDLE;
                        end
                    end
                    SKIP: begin
                        if (skip_cnt <= SW'(1)) begin
                            state    <= IDLE;
                            skip_cnt <= '0;
                        end else begin
                            skip_cnt <= skip_cnt - SW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // Stalled mid-sequence: abandon the partial code once the gap is too long.
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    tmo_cnt  <= '0;
                    skip_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: vector table plus hand-written multi-cycle sequences.
module tb_ps2_key_decoder;

    localparam int TMO = 20;

`ifdef TYPEMATIC_FILTER_EN
    localparam int MK_P = 1;
    localparam int BR_P = 1;
`else
    localparam int MK_P = 3;
    localparam int BR_P = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_err = 1'b0;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         been_ready;
    logic         any_key;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .PAUSE_SKIP(7)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_err(rx_err),
        .key_down(key_down),
        .last_change(last_change),
        .been_ready(been_ready),
        .any_key(any_key)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (been_ready) pulse_cnt++;

    typedef struct {
        logic [7:0] data;
        logic [8:0] idx;
        logic       bit_v;
        logic [8:0] last;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic [8:0] i, input logic b,
                                input logic [8:0] l, input logic r);
        vec_t v;
        v.data = d; v.idx = i; v.bit_v = b; v.last = l; v.rdy = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        int exp_p;
        logic [7:0] rel [4];

        // Table: one byte per row, checked at the negedge following its strobe edge.
        tbl.push_back(mk(8'h16, 9'h016, 1'b1, 9'h016, 1'b1));
        tbl.push_back(mk(8'hF0, 9'h016, 1'b1, 9'h016, 1'b0));
        tbl.push_back(mk(8'h16, 9'h016, 1'b0, 9'h016, 1'b1));
        tbl.push_back(mk(8'hE0, 9'h175, 1'b0, 9'h016, 1'b0));
        tbl.push_back(mk(8'h75, 9'h175, 1'b1, 9'h175, 1'b1));
        tbl.push_back(mk(8'hE0, 9'h075, 1'b0, 9'h175, 1'b0));
        tbl.push_back(mk(8'hF0, 9'h175, 1'b1, 9'h175, 1'b0));
        tbl.push_back(mk(8'h75, 9'h175, 1'b0, 9'h175, 1'b1));
        tbl.push_back(mk(8'h1C, 9'h01C, 1'b1, 9'h01C, 1'b1));
        tbl.push_back(mk(8'h1B, 9'h01B, 1'b1, 9'h01B, 1'b1));
        tbl.push_back(mk(8'hF0, 9'h01C, 1'b1, 9'h01B, 1'b0));
        tbl.push_back(mk(8'h1C, 9'h01C, 1'b0, 9'h01C, 1'b1));
        tbl.push_back(mk(8'hFA, 9'h01B, 1'b1, 9'h01C, 1'b0));
        tbl.push_back(mk(8'hAA, 9'h01C, 1'b0, 9'h01C, 1'b0));
        tbl.push_back(mk(8'hE0, 9'h111, 1'b0, 9'h01C, 1'b0));
        tbl.push_back(mk(8'hE0, 9'h111, 1'b0, 9'h01C, 1'b0));
        tbl.push_back(mk(8'h11, 9'h111, 1'b1, 9'h111, 1'b1));
        tbl.push_back(mk(8'hE0, 9'h111, 1'b1, 9'h111, 1'b0));
        tbl.push_back(mk(8'hF0, 9'h111, 1'b1, 9'h111, 1'b0));
        tbl.push_back(mk(8'h11, 9'h111, 1'b0, 9'h111, 1'b1));
        tbl.push_back(mk(8'hE1, 9'h014, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'h14, 9'h014, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'h77, 9'h077, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'hE1, 9'h0E1, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'hF0, 9'h0F0, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'h14, 9'h014, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'hF0, 9'h0F0, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'h77, 9'h077, 1'b0, 9'h111, 1'b0));
        tbl.push_back(mk(8'h29, 9'h029, 1'b1, 9'h029, 1'b1));

        // Reset state
        idle(2);
        check("rst key_down", key_down, '0);
        check("rst last_change", last_change, 9'h000);
        check("rst been_ready", been_ready, 1'b0);
        check("rst any_key", any_key, 1'b0);
        rst = 1'b1;
        idle(1);

        p0 = pulse_cnt;
        exp_p = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data);
            check($sformatf("v%0d been_ready", i), been_ready, tbl[i].rdy);
            check($sformatf("v%0d key_down[%0h]", i, tbl[i].idx), key_down[tbl[i].idx], tbl[i].bit_v);
            check($sformatf("v%0d last_change", i), last_change, tbl[i].last);
            if (tbl[i].rdy) exp_p++;
        end
        idle(1);
        #1;
        check("table pulse count", pulse_cnt - p0, exp_p);
        check("key_down[075] never set", key_down[9'h075], 1'b0);
        check("any_key two held", any_key, 1'b1);

        // any_key trails key_down by one clock
        send(8'hF0); send(8'h1B);
        check("any_key one held", any_key, 1'b1);
        send(8'hF0); send(8'h29);
        check("key_down[029] released", key_down[9'h029], 1'b0);
        check("any_key lag", any_key, 1'b1);
        idle(1);
        check("any_key cleared", any_key, 1'b0);

        // Back-to-back strobes
        @(negedge clk); rx_data = 8'h1C; rx_valid = 1'b1;
        @(negedge clk); rx_data = 8'h1B;
        check("b2b rdy0", been_ready, 1'b1);
        check("b2b last0", last_change, 9'h01C);
        @(negedge clk); rx_valid = 1'b0;
        check("b2b rdy1", been_ready, 1'b1);
        check("b2b last1", last_change, 9'h01B);
        check("b2b both held", {key_down[9'h01C], key_down[9'h01B]}, 2'b11);
        rel[0] = 8'hF0; rel[1] = 8'h1C; rel[2] = 8'hF0; rel[3] = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rx_data = rel[i]; rx_valid = 1'b1;
        end
        @(negedge clk); rx_valid = 1'b0;
        check("b2b both released", {key_down[9'h01C], key_down[9'h01B]}, 2'b00);
        check("b2b release last", last_change, 9'h01B);

        // Short gap keeps the break prefix, long gap times it out
        send(8'h1C);
        send(8'hF0); idle(TMO / 2); send(8'h1C);
        check("short gap break", key_down[9'h01C], 1'b0);
        send(8'hF0); idle(TMO + 2); send(8'h1C);
        check("timeout make", key_down[9'h01C], 1'b1);
        check("timeout make rdy", been_ready, 1'b1);
        check("timeout make last", last_change, 9'h01C);
        send(8'hF0); send(8'h1C);
        check("timeout release", key_down[9'h01C], 1'b0);

        // rx_err discards a pending prefix
        send(8'hE0);
        @(negedge clk); rx_err = 1'b1;
        @(negedge clk); rx_err = 1'b0;
        check("err no pulse", been_ready, 1'b0);
        send(8'h75);
        check("err make 075", key_down[9'h075], 1'b1);
        check("err not 175", key_down[9'h175], 1'b0);
        check("err last", last_change, 9'h075);
        send(8'hF0);
        @(negedge clk); rx_data = 8'h75; rx_valid = 1'b1; rx_err = 1'b1;
        @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
        check("err+valid dropped rdy", been_ready, 1'b0);
        check("err+valid dropped bit", key_down[9'h075], 1'b1);
        send(8'hF0); send(8'h75);
        check("release 075", key_down[9'h075], 1'b0);

        // Typematic repeats
        idle(1); #1;
        p0 = pulse_cnt;
        send(8'h1E); send(8'h1E); send(8'h1E);
        idle(1); #1;
        check("repeat make pulses", pulse_cnt - p0, MK_P);
        check("repeat make bit", key_down[9'h01E], 1'b1);
        p0 = pulse_cnt;
        send(8'hF0); send(8'h1E); send(8'hF0); send(8'h1E);
        idle(1); #1;
        check("repeat break pulses", pulse_cnt - p0, BR_P);
        check("repeat break bit", key_down[9'h01E], 1'b0);

        // Async reset in the middle of an extended sequence
        send(8'h1C);
        send(8'hE0);
        check("pre-reset held", key_down[9'h01C], 1'b1);
        #2; rst = 1'b0; #1;
        check("async rst key_down", key_down, '0);
        check("async rst last", last_change, 9'h000);
        check("async rst any_key", any_key, 1'b0);
        check("async rst rdy", been_ready, 1'b0);
        @(negedge clk); rst = 1'b1;
        send(8'h75);
        check("post-reset make 075", key_down[9'h075], 1'b1);
        check("post-reset not 175", key_down[9'h175], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
